// File: rtl/bus_pkg.sv
// Shared types and widths for the core's external memory bus.
package bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FETCH = 2'd1,
        ARB_DATA  = 2'd2
    } arb_state_t;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_STRB_W = 4;

endpackage

// File: rtl/bus_arbiter.sv
// Arbitrates the single external bus between instruction fetch and data access,
// one transaction at a time, with a bounded data-priority streak.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int MAX_DATA_BURST = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [BUS_ADDR_W-1:0] fetch_addr,
    input  logic                  fetch_flush,
    output logic [BUS_DATA_W-1:0] fetch_data,
    output logic                  fetch_ready,
    input  logic                  mem_req,
    input  logic [BUS_ADDR_W-1:0] mem_addr,
    input  logic                  mem_we,
    input  logic [BUS_DATA_W-1:0] mem_wdata,
    input  logic [BUS_STRB_W-1:0] mem_strb,
    output logic [BUS_DATA_W-1:0] mem_rdata,
    output logic                  mem_ready,
    output logic                  bus_valid,
    output logic [BUS_ADDR_W-1:0] bus_addr,
    output logic [BUS_DATA_W-1:0] bus_wdata,
    output logic                  bus_we,
    output logic [BUS_STRB_W-1:0] bus_strb,
    input  logic                  bus_ready,
    input  logic [BUS_DATA_W-1:0] bus_rdata
);

    localparam int STREAK_W = $clog2(MAX_DATA_BURST + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_BURST);

    arb_state_t            state_reg, state_next;
    logic [STREAK_W-1:0]   streak_reg, streak_next;
    logic                  discard_reg, discard_next;
    logic [BUS_ADDR_W-1:0] bus_addr_reg, bus_addr_next;
    logic [BUS_DATA_W-1:0] bus_wdata_reg, bus_wdata_next;
    logic                  bus_we_reg, bus_we_next;
    logic [BUS_STRB_W-1:0] bus_strb_reg, bus_strb_next;
    logic [BUS_DATA_W-1:0] fetch_data_reg, fetch_data_next;
    logic                  fetch_ready_reg, fetch_ready_next;
    logic [BUS_DATA_W-1:0] mem_rdata_reg, mem_rdata_next;
    logic                  mem_ready_reg, mem_ready_next;

    logic fetch_cand;
    logic data_wins;

    assign fetch_cand = fetch_req && !fetch_flush;
    // Data normally wins; once the streak hits the limit a waiting fetch goes first.
    assign data_wins  = mem_req && !((streak_reg == STREAK_MAX) && fetch_cand);

    always_comb begin
        state_next       = state_reg;
        streak_next      = streak_reg;
        discard_next     = discard_reg;
        bus_addr_next    = bus_addr_reg;
        bus_wdata_next   = bus_wdata_reg;
        bus_we_next      = bus_we_reg;
        bus_strb_next    = bus_strb_reg;
        fetch_data_next  = fetch_data_reg;
        fetch_ready_next = 1'b0;
        mem_rdata_next   = mem_rdata_reg;
        mem_ready_next   = 1'b0;

        case (state_reg)
            ARB_IDLE: begin
                if (data_wins) begin
                    state_next     = ARB_DATA;
                    bus_addr_next  = mem_addr;
                    bus_wdata_next = mem_wdata;
                    bus_we_next    = mem_we;
                    bus_strb_next  = mem_strb;
                    if (streak_reg != STREAK_MAX) begin
                        streak_next = streak_reg + 1'b1;
                    end
                end else if (fetch_cand) begin
                    state_next     = ARB_FETCH;
                    bus_addr_next  = fetch_addr;
                    bus_wdata_next = '0;
                    bus_we_next    = 1'b0;
                    bus_strb_next  = '1;
                    streak_next    = '0;
                end
            end
            ARB_FETCH: begin
                if (bus_ready) begin
                    fetch_data_next  = bus_rdata;
                    fetch_ready_next = !discard_reg && !fetch_flush;
                    discard_next     = 1'b0;
                    state_next       = ARB_IDLE;
                end else if (fetch_flush) begin
                    discard_next = 1'b1;
                end
            end
            ARB_DATA: begin
                if (bus_ready) begin
                    mem_rdata_next = bus_rdata;
                    mem_ready_next = 1'b1;
                    state_next     = ARB_IDLE;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ARB_IDLE;
            streak_reg      <= '0;
            discard_reg     <= 1'b0;
            bus_addr_reg    <= '0;
            bus_wdata_reg   <= '0;
            bus_we_reg      <= 1'b0;
            bus_strb_reg    <= '0;
            fetch_data_reg  <= '0;
            fetch_ready_reg <= 1'b0;
            mem_rdata_reg   <= '0;
            mem_ready_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            streak_reg      <= streak_next;
            discard_reg     <= discard_next;
            bus_addr_reg    <= bus_addr_next;
            bus_wdata_reg   <= bus_wdata_next;
            bus_we_reg      <= bus_we_next;
            bus_strb_reg    <= bus_strb_next;
            fetch_data_reg  <= fetch_data_next;
            fetch_ready_reg <= fetch_ready_next;
            mem_rdata_reg   <= mem_rdata_next;
            mem_ready_reg   <= mem_ready_next;
        end
    end

    assign bus_valid   = (state_reg != ARB_IDLE);
    assign bus_addr    = bus_addr_reg;
    assign bus_wdata   = bus_wdata_reg;
    assign bus_we      = bus_we_reg;
    assign bus_strb    = bus_strb_reg;
    assign fetch_data  = fetch_data_reg;
    assign fetch_ready = fetch_ready_reg;
    assign mem_rdata   = mem_rdata_reg;
    assign mem_ready   = mem_ready_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: inputs change 1 time unit after each rising
// edge and outputs are sampled at that same point, well away from the edge.
module tb_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_flush;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_strb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_valid;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic [3:0]  bus_strb;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.MAX_DATA_BURST(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_flush (fetch_flush),
        .fetch_data  (fetch_data),
        .fetch_ready (fetch_ready),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_strb    (mem_strb),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .bus_valid   (bus_valid),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_we      (bus_we),
        .bus_strb    (bus_strb),
        .bus_ready   (bus_ready),
        .bus_rdata   (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-24s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One zero-wait grant with bus_ready already high: valid cycle, then the pulse cycle.
    task automatic grant(input string tag, input logic is_fetch, input logic [31:0] addr);
        tick();
        check({tag, "_valid"}, 32'(bus_valid), 32'd1);
        check({tag, "_addr"}, bus_addr, addr);
        tick();
        check({tag, "_fready"}, 32'(fetch_ready), 32'(is_fetch));
        check({tag, "_mready"}, 32'(mem_ready), 32'(!is_fetch));
    endtask

    initial begin
        reset = 1'b1;
        fetch_req = 1'b0; fetch_addr = '0; fetch_flush = 1'b0;
        mem_req = 1'b0; mem_addr = '0; mem_we = 1'b0; mem_wdata = '0; mem_strb = '0;
        bus_ready = 1'b0; bus_rdata = '0;

        // Reset state
        tick();
        tick();
        check("rst_valid", 32'(bus_valid), 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_strb", 32'(bus_strb), 32'd0);
        check("rst_fready", 32'(fetch_ready), 32'd0);
        check("rst_mready", 32'(mem_ready), 32'd0);
        check("rst_fdata", fetch_data, 32'd0);

        // Fetch alone
        reset = 1'b0;
        fetch_req = 1'b1; fetch_addr = 32'h100;
        tick();
        check("f1_valid", 32'(bus_valid), 32'd1);
        check("f1_addr", bus_addr, 32'h100);
        check("f1_we", 32'(bus_we), 32'd0);
        check("f1_strb", 32'(bus_strb), 32'hF);
        bus_ready = 1'b1; bus_rdata = 32'h0000_0013;
        tick();
        check("f1_fready", 32'(fetch_ready), 32'd1);
        check("f1_fdata", fetch_data, 32'h0000_0013);
        check("f1_idle", 32'(bus_valid), 32'd0);
        fetch_req = 1'b0; bus_ready = 1'b0;
        tick();
        check("f1_pulse_end", 32'(fetch_ready), 32'd0);

        // Simultaneous fetch and store: data first, fetch two cycles later
        fetch_req = 1'b1; fetch_addr = 32'h104;
        mem_req = 1'b1; mem_addr = 32'h2000; mem_we = 1'b1; mem_wdata = 32'hDEAD_BEEF; mem_strb = 4'hF;
        tick();
        check("sim_addr", bus_addr, 32'h2000);
        check("sim_we", 32'(bus_we), 32'd1);
        check("sim_strb", 32'(bus_strb), 32'hF);
        check("sim_wdata", bus_wdata, 32'hDEAD_BEEF);
        bus_ready = 1'b1; bus_rdata = 32'h55;
        tick();
        check("sim_mready", 32'(mem_ready), 32'd1);
        check("sim_no_fready", 32'(fetch_ready), 32'd0);
        mem_req = 1'b0; bus_ready = 1'b0;
        tick();
        check("sim_f_valid", 32'(bus_valid), 32'd1);
        check("sim_f_addr", bus_addr, 32'h104);
        check("sim_f_we", 32'(bus_we), 32'd0);
        bus_ready = 1'b1; bus_rdata = 32'h17;
        tick();
        check("sim_f_fready", 32'(fetch_ready), 32'd1);
        check("sim_f_fdata", fetch_data, 32'h17);
        fetch_req = 1'b0; bus_ready = 1'b0;
        tick();

        // Starvation bound: D,D,F,D,D,F with both requests held and zero wait states
        fetch_req = 1'b1; fetch_addr = 32'h108;
        mem_req = 1'b1; mem_addr = 32'h3000; mem_we = 1'b0; mem_strb = 4'hF;
        bus_ready = 1'b1; bus_rdata = 32'h77;
        grant("st_d0", 1'b0, 32'h3000);
        grant("st_d1", 1'b0, 32'h3000);
        grant("st_f2", 1'b1, 32'h108);
        grant("st_d3", 1'b0, 32'h3000);
        grant("st_d4", 1'b0, 32'h3000);
        grant("st_f5", 1'b1, 32'h108);
        fetch_req = 1'b0; mem_req = 1'b0; bus_ready = 1'b0;
        tick();

        // Wait states: attributes held for 5 cycles, exactly one pulse
        mem_req = 1'b1; mem_addr = 32'h4000; mem_we = 1'b1; mem_wdata = 32'h1234_5678; mem_strb = 4'h3;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("ws_addr", bus_addr, 32'h4000);
            check("ws_wdata", bus_wdata, 32'h1234_5678);
            check("ws_strb", 32'(bus_strb), 32'h3);
            check("ws_we", 32'(bus_we), 32'd1);
            check("ws_no_mready", 32'(mem_ready), 32'd0);
            if (i == 4) begin
                bus_ready = 1'b1; bus_rdata = 32'hCAFE_0001;
            end
            tick();
        end
        check("ws_mready", 32'(mem_ready), 32'd1);
        check("ws_rdata", mem_rdata, 32'hCAFE_0001);
        mem_req = 1'b0; bus_ready = 1'b0;
        tick();
        check("ws_pulse_end", 32'(mem_ready), 32'd0);

        // Flush mid-fetch with 3 wait states: result dropped
        fetch_req = 1'b1; fetch_addr = 32'h200;
        tick();
        check("fl_addr", bus_addr, 32'h200);
        tick();
        fetch_flush = 1'b1;
        tick();
        fetch_flush = 1'b0; fetch_req = 1'b0;
        tick();
        check("fl_still_valid", 32'(bus_valid), 32'd1);
        bus_ready = 1'b1; bus_rdata = 32'h99;
        tick();
        check("fl_no_fready", 32'(fetch_ready), 32'd0);
        check("fl_idle", 32'(bus_valid), 32'd0);
        bus_ready = 1'b0;
        fetch_req = 1'b1; fetch_addr = 32'h400;
        tick();
        check("fl_next_addr", bus_addr, 32'h400);
        bus_ready = 1'b1; bus_rdata = 32'hAA;
        tick();
        check("fl_next_fready", 32'(fetch_ready), 32'd1);
        check("fl_next_fdata", fetch_data, 32'hAA);
        fetch_req = 1'b0; bus_ready = 1'b0;
        tick();

        // Flush coincident with bus_ready
        fetch_req = 1'b1; fetch_addr = 32'h500;
        tick();
        check("flc_addr", bus_addr, 32'h500);
        bus_ready = 1'b1; bus_rdata = 32'hBB; fetch_flush = 1'b1;
        tick();
        check("flc_no_fready", 32'(fetch_ready), 32'd0);
        check("flc_idle", 32'(bus_valid), 32'd0);
        fetch_req = 1'b0; fetch_flush = 1'b0; bus_ready = 1'b0;
        tick();
        check("flc_no_late", 32'(fetch_ready), 32'd0);

        // Reset mid-DATA: outputs cleared, streak restarts at 0 (D,D,F afterwards)
        fetch_req = 1'b1; fetch_addr = 32'h600;
        mem_req = 1'b1; mem_addr = 32'h6000; mem_we = 1'b1; mem_wdata = 32'h0BAD_F00D; mem_strb = 4'hF;
        tick();
        check("rd_valid", 32'(bus_valid), 32'd1);
        check("rd_addr", bus_addr, 32'h6000);
        reset = 1'b1; bus_ready = 1'b1; bus_rdata = 32'hEE;
        tick();
        check("rd_valid0", 32'(bus_valid), 32'd0);
        check("rd_addr0", bus_addr, 32'd0);
        check("rd_wdata0", bus_wdata, 32'd0);
        check("rd_we0", 32'(bus_we), 32'd0);
        check("rd_mready0", 32'(mem_ready), 32'd0);
        check("rd_mrdata0", mem_rdata, 32'd0);
        check("rd_fdata0", fetch_data, 32'd0);
        reset = 1'b0;
        grant("rd_d0", 1'b0, 32'h6000);
        grant("rd_d1", 1'b0, 32'h6000);
        grant("rd_f2", 1'b1, 32'h600);
        fetch_req = 1'b0; mem_req = 1'b0; bus_ready = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
